// File: rtl/pss_peak_detector.sv
// PSS peak detector: moving-average noise floor, threshold trigger, windowed max search, holdoff.
// Define PSS_PEAK_CFO_EN to capture C0_i/C1_i alongside the peak; otherwise C0_o/C1_o read 0.
module pss_peak_detector #(
    parameter int IN_DW           = 24,
    parameter int C_DW            = 94,
    parameter int WINDOW_LEN      = 64,
    parameter int DETECTION_SHIFT = 4,
    parameter int PEAK_WINDOW     = 8,
    parameter int HOLDOFF_LEN     = 256,
    parameter int SAMPLE_CNT_DW   = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [IN_DW-1:0]         s_axis_in_tdata,
    input  logic                     s_axis_in_tvalid,
    input  logic [C_DW-1:0]          C0_i,
    input  logic [C_DW-1:0]          C1_i,
    output logic                     m_axis_out_tvalid,
    output logic [IN_DW-1:0]         peak_value_o,
    output logic [SAMPLE_CNT_DW-1:0] peak_pos_o,
    output logic [C_DW-1:0]          C0_o,
    output logic [C_DW-1:0]          C1_o,
    output logic [1:0]               state_o
);

    localparam int LOG2W = $clog2(WINDOW_LEN);
    localparam int SUM_W = IN_DW + LOG2W;
    localparam int TH_W  = IN_DW + DETECTION_SHIFT;
    localparam int PW_W  = $clog2(PEAK_WINDOW + 1);
    localparam int HO_W  = (HOLDOFF_LEN > 0) ? $clog2(HOLDOFF_LEN + 1) : 1;

    localparam logic [LOG2W-1:0] WM_LAST = LOG2W'(WINDOW_LEN - 1);
    localparam logic [PW_W-1:0]  PW_LAST = PW_W'(PEAK_WINDOW - 1);
    localparam logic [HO_W-1:0]  HO_LAST = HO_W'((HOLDOFF_LEN > 0) ? HOLDOFF_LEN - 1 : 0);

    typedef enum logic [1:0] {
        ST_WARMUP  = 2'd0,
        ST_IDLE    = 2'd1,
        ST_SEARCH  = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    state_t                   state_q;
    logic [SAMPLE_CNT_DW-1:0] sample_cnt;
    logic [IN_DW-1:0]         dly [WINDOW_LEN];
    logic [SUM_W-1:0]         sum;
    logic [LOG2W-1:0]         warm_cnt;
    logic [PW_W-1:0]          srch_cnt;
    logic [HO_W-1:0]          ho_cnt;
    logic [IN_DW-1:0]         max_val;
    logic [SAMPLE_CNT_DW-1:0] max_pos;

    logic                     accept;
    logic [IN_DW-1:0]         avg;
    logic [TH_W-1:0]          thr;
    logic                     over_thr;
    logic                     trigger;
    logic                     take;
    logic                     last;
    logic [IN_DW-1:0]         cand_val;
    logic [SAMPLE_CNT_DW-1:0] cand_pos;

    // Threshold uses the sum before the current sample enters the window.
    assign accept   = s_axis_in_tvalid;
    assign avg      = sum[SUM_W-1:LOG2W];
    assign thr      = TH_W'(avg) << DETECTION_SHIFT;
    assign over_thr = TH_W'(s_axis_in_tdata) > thr;
    assign trigger  = accept && (state_q == ST_IDLE) && over_thr;
    // Strict compare keeps the earliest sample on ties; the trigger always seeds.
    assign take     = trigger ||
                      (accept && (state_q == ST_SEARCH) && (s_axis_in_tdata > max_val));
    assign last     = (trigger && (PEAK_WINDOW == 1)) ||
                      (accept && (state_q == ST_SEARCH) && (srch_cnt == PW_LAST));
    assign cand_val = take ? s_axis_in_tdata : max_val;
    assign cand_pos = take ? sample_cnt : max_pos;
    assign state_o  = state_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q           <= ST_WARMUP;
            sample_cnt        <= '0;
            sum               <= '0;
            warm_cnt          <= '0;
            srch_cnt          <= '0;
            ho_cnt            <= '0;
            max_val           <= '0;
            max_pos           <= '0;
            m_axis_out_tvalid <= 1'b0;
            peak_value_o      <= '0;
            peak_pos_o        <= '0;
            for (int k = 0; k < WINDOW_LEN; k++) dly[k] <= '0;
        end else begin
            m_axis_out_tvalid <= 1'b0;
            if (accept) begin
                sample_cnt <= sample_cnt + SAMPLE_CNT_DW'(1);
                dly[0]     <= s_axis_in_tdata;
                for (int k = 1; k < WINDOW_LEN; k++) dly[k] <= dly[k-1];
                sum        <= sum + SUM_W'(s_axis_in_tdata) - SUM_W'(dly[WINDOW_LEN-1]);

                if (take) begin
                    max_val <= s_axis_in_tdata;
                    max_pos <= sample_cnt;
                end

                case (state_q)
                    ST_WARMUP: begin
                        if (warm_cnt == WM_LAST) state_q <= ST_IDLE;
                        else                     warm_cnt <= warm_cnt + LOG2W'(1);
                    end
                    ST_IDLE: begin
                        if (over_thr) begin
                            state_q  <= ST_SEARCH;
                            srch_cnt <= PW_W'(1);
                        end
                    end
                    ST_SEARCH: begin
                        srch_cnt <= srch_cnt + PW_W'(1);
                    end
                    ST_HOLDOFF: begin
                        if (ho_cnt == HO_LAST) state_q <= ST_IDLE;
                        else                   ho_cnt  <= ho_cnt + HO_W'(1);
                    end
                    default: state_q <= ST_WARMUP;
                endcase

                // Report overrides the per-state next state above.
                if (last) begin
                    m_axis_out_tvalid <= 1'b1;
                    peak_value_o      <= cand_val;
                    peak_pos_o        <= cand_pos;
                    ho_cnt            <= '0;
                    state_q           <= (HOLDOFF_LEN == 0) ? ST_IDLE : ST_HOLDOFF;
                end
            end
        end
    end

`ifdef PSS_PEAK_CFO_EN
    logic [C_DW-1:0] max_c0;
    logic [C_DW-1:0] max_c1;
    logic [C_DW-1:0] cand_c0;
    logic [C_DW-1:0] cand_c1;

    assign cand_c0 = take ? C0_i : max_c0;
    assign cand_c1 = take ? C1_i : max_c1;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            max_c0 <= '0;
            max_c1 <= '0;
            C0_o   <= '0;
            C1_o   <= '0;
        end else if (accept) begin
            if (take) begin
                max_c0 <= C0_i;
                max_c1 <= C1_i;
            end
            if (last) begin
                C0_o <= cand_c0;
                C1_o <= cand_c1;
            end
        end
    end
`else
    logic unused_c;
    assign unused_c = ^{C0_i, C1_i};
    assign C0_o     = '0;
    assign C1_o     = '0;
`endif

endmodule

// File: tb/tb_pss_peak_detector.sv
// Directed bench for pss_peak_detector with WINDOW_LEN=4, DETECTION_SHIFT=2, PEAK_WINDOW=4, HOLDOFF_LEN=8.
module tb_pss_peak_detector;

    localparam int IN_DW = 24;
    localparam int C_DW  = 94;
    localparam int CW    = 32;
`ifdef PSS_PEAK_CFO_EN
    localparam bit CFO = 1'b1;
`else
    localparam bit CFO = 1'b0;
`endif

    logic             clk_i   = 1'b0;
    logic             reset_i = 1'b1;
    logic [IN_DW-1:0] s_axis_in_tdata  = '0;
    logic             s_axis_in_tvalid = 1'b0;
    logic [C_DW-1:0]  C0_i = '0;
    logic [C_DW-1:0]  C1_i = '0;
    logic             m_axis_out_tvalid;
    logic [IN_DW-1:0] peak_value_o;
    logic [CW-1:0]    peak_pos_o;
    logic [C_DW-1:0]  C0_o;
    logic [C_DW-1:0]  C1_o;
    logic [1:0]       state_o;

    always #5 clk_i = ~clk_i;

    pss_peak_detector #(
        .IN_DW(IN_DW), .C_DW(C_DW), .WINDOW_LEN(4), .DETECTION_SHIFT(2),
        .PEAK_WINDOW(4), .HOLDOFF_LEN(8), .SAMPLE_CNT_DW(CW)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .s_axis_in_tdata(s_axis_in_tdata), .s_axis_in_tvalid(s_axis_in_tvalid),
        .C0_i(C0_i), .C1_i(C1_i),
        .m_axis_out_tvalid(m_axis_out_tvalid), .peak_value_o(peak_value_o),
        .peak_pos_o(peak_pos_o), .C0_o(C0_o), .C1_o(C1_o), .state_o(state_o)
    );

    typedef struct {
        logic [IN_DW-1:0] score;
        logic             exp_vld;
        logic [1:0]       exp_state;
        logic [IN_DW-1:0] exp_val;
        logic [CW-1:0]    exp_pos;
        int               exp_cidx;   // sample index whose C inputs should be on C*_o, -1 for zero
    } vec_t;

    vec_t tbl [58];
    int   n_cmp = 0;
    int   n_err = 0;
    int   pulses;

    function automatic logic [C_DW-1:0] c0_of(input int i);
        return (C_DW'(i) << 40) | C_DW'(i + 7);
    endfunction

    function automatic logic [C_DW-1:0] c1_of(input int i);
        return ~c0_of(i);
    endfunction

    function automatic logic [C_DW-1:0] exp_c(input int cidx, input bit second);
        if (!CFO || cidx < 0) return '0;
        return second ? c1_of(cidx) : c0_of(cidx);
    endfunction

    // Expected state after accepting sample i of a fresh run whose first trigger is at idx20.
    function automatic logic [1:0] exp_st_run(input int i);
        if (i <= 2)  return 2'd0;
        if (i <= 19) return 2'd1;
        if (i <= 22) return 2'd2;
        return 2'd3;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic vld, input logic [1:0] st,
                           input logic [IN_DW-1:0] val, input logic [CW-1:0] pos, input int cidx);
        chk({tag, ".tvalid"}, 128'(m_axis_out_tvalid), 128'(vld));
        chk({tag, ".state"},  128'(state_o), 128'(st));
        chk({tag, ".value"},  128'(peak_value_o), 128'(val));
        chk({tag, ".pos"},    128'(peak_pos_o), 128'(pos));
        chk({tag, ".c0"},     128'(C0_o), 128'(exp_c(cidx, 1'b0)));
        chk({tag, ".c1"},     128'(C1_o), 128'(exp_c(cidx, 1'b1)));
    endtask

    task automatic step(input logic [IN_DW-1:0] sc, input logic v, input int idx);
        s_axis_in_tdata  = sc;
        s_axis_in_tvalid = v;
        C0_i = c0_of(idx);
        C1_i = c1_of(idx);
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset_i          = 1'b1;
        s_axis_in_tvalid = 1'b0;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        chk_all(tag, 1'b0, 2'd0, '0, '0, -1);
    endtask

    // Background 10, trigger 100 at idx20, peak at idx21, idx22 = s22, then 10s.
    function automatic logic [IN_DW-1:0] run_score(input int i, input logic [IN_DW-1:0] s22);
        case (i)
            20:      return 24'd100;
            21:      return 24'd200;
            22:      return s22;
            default: return 24'd10;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 58; i++) begin
            tbl[i].score   = 24'd10;
            tbl[i].exp_vld = (i == 23) || (i == 43);
            if      (i <= 2)  tbl[i].exp_state = 2'd0;
            else if (i <= 19) tbl[i].exp_state = 2'd1;
            else if (i <= 22) tbl[i].exp_state = 2'd2;
            else if (i <= 30) tbl[i].exp_state = 2'd3;
            else if (i <= 39) tbl[i].exp_state = 2'd1;
            else if (i <= 42) tbl[i].exp_state = 2'd2;
            else if (i <= 50) tbl[i].exp_state = 2'd3;
            else if (i <= 55) tbl[i].exp_state = 2'd1;
            else              tbl[i].exp_state = 2'd2;
            if (i < 23) begin
                tbl[i].exp_val = '0;     tbl[i].exp_pos = '0;  tbl[i].exp_cidx = -1;
            end else if (i < 43) begin
                tbl[i].exp_val = 24'd200; tbl[i].exp_pos = 21; tbl[i].exp_cidx = 21;
            end else begin
                tbl[i].exp_val = 24'd500; tbl[i].exp_pos = 40; tbl[i].exp_cidx = 40;
            end
        end
        tbl[10].score = 24'd40;   // equals threshold: strict compare must not trigger
        tbl[20].score = 24'd100;
        tbl[21].score = 24'd200;
        tbl[22].score = 24'd150;
        tbl[25].score = 24'd500;  // inside holdoff
        tbl[40].score = 24'd500;
        tbl[56].score = 24'd100;
        tbl[57].score = 24'd200;

        // Main scenario: two reports separated by holdoff, then a search left pending.
        do_reset("rst0");
        for (int i = 0; i < 58; i++) begin
            step(tbl[i].score, 1'b1, i);
            chk_all($sformatf("main[%0d]", i), tbl[i].exp_vld, tbl[i].exp_state,
                    tbl[i].exp_val, tbl[i].exp_pos, tbl[i].exp_cidx);
        end

        // Asynchronous reset mid-SEARCH: outputs clear before any clock edge, no report follows.
        s_axis_in_tdata  = 24'd150;
        s_axis_in_tvalid = 1'b1;
        #3;
        reset_i = 1'b1;
        #1;
        chk_all("async_rst", 1'b0, 2'd0, '0, '0, -1);
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        chk_all("rst_hold", 1'b0, 2'd0, '0, '0, -1);
        pulses = 0;
        for (int i = 0; i < 28; i++) begin
            step(run_score(i, 24'd150), 1'b1, i);
            if (i < 23 && m_axis_out_tvalid) pulses++;
            chk($sformatf("restart_st[%0d]", i), 128'(state_o), 128'(exp_st_run(i)));
            if (i == 23) chk_all("restart_rep", 1'b1, 2'd3, 24'd200, 21, 21);
        end
        chk("restart_early_pulses", 128'(pulses), 128'(0));

        // Constant floor: never crosses 4*avg.
        do_reset("rst1");
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            step(24'd10, 1'b1, i);
            if (m_axis_out_tvalid) pulses++;
            chk($sformatf("const_st[%0d]", i), 128'(state_o), 128'(i < 3 ? 2'd0 : 2'd1));
        end
        chk("const_pulses", 128'(pulses), 128'(0));

        // Large scores during warm-up are never detected.
        do_reset("rst2");
        for (int i = 0; i < 10; i++) begin
            step(i < 4 ? 24'd1000 : 24'd10, 1'b1, i);
            chk($sformatf("warm_vld[%0d]", i), 128'(m_axis_out_tvalid), 128'(0));
            chk($sformatf("warm_st[%0d]", i), 128'(state_o), 128'(i < 3 ? 2'd0 : 2'd1));
        end

        // Tie at idx21/idx22, without and with tvalid gaps carrying junk scores.
        for (int g = 0; g < 2; g++) begin
            do_reset($sformatf("rst_tie%0d", g));
            pulses = 0;
            for (int i = 0; i < 28; i++) begin
                step(run_score(i, 24'd200), 1'b1, i);
                if (m_axis_out_tvalid) pulses++;
                chk($sformatf("tie%0d_st[%0d]", g, i), 128'(state_o), 128'(exp_st_run(i)));
                if (i == 23) chk_all($sformatf("tie%0d_rep", g), 1'b1, 2'd3, 24'd200, 21, 21);
                if (g == 1 && i >= 18) begin
                    step(24'd999, 1'b0, 1000 + i);
                    if (m_axis_out_tvalid) pulses++;
                    chk($sformatf("tie_gap_st[%0d]", i), 128'(state_o), 128'(exp_st_run(i)));
                    chk($sformatf("tie_gap_vld[%0d]", i), 128'(m_axis_out_tvalid), 128'(0));
                end
            end
            chk($sformatf("tie%0d_pulses", g), 128'(pulses), 128'(1));
            chk($sformatf("tie%0d_hold_val", g), 128'(peak_value_o), 128'(200));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pss_peak_detector.md
# pss_peak_detector

Downstream consumer of the PSS correlator magnitude stream. Tracks a moving-average noise floor and flags a score exceeding a scaled multiple of that floor. Searches a short window for the local maximum, reports its value and absolute sample index, then holds off re-detection. Sits between the PSS correlator and the frame-sync / CFO-correction logic.

## Interface
- IN_DW, 24, correlator score width (unsigned magnitude)
- C_DW, 94, width of partial-sum inputs C0_i/C1_i (packed {im, re})
- WINDOW_LEN, 64, moving-average length in samples; power of two, ≥ 2
- DETECTION_SHIFT, 4, threshold = average · 2^DETECTION_SHIFT
- PEAK_WINDOW, 8, samples searched for the maximum, trigger sample included
- HOLDOFF_LEN, 256, samples ignored after a reported peak
- SAMPLE_CNT_DW, 32, sample index width
- clk_i  in  1  clock; single clock domain
- reset_i  in  1  asynchronous, active-high reset
- s_axis_in_tdata  in  IN_DW  correlator score
- s_axis_in_tvalid  in  1  score valid; no backpressure
- C0_i, C1_i  in  C_DW  correlator partial sums aligned with the score
- m_axis_out_tvalid  out  1  one-cycle pulse: peak report valid
- peak_value_o  out  IN_DW  maximum score in the search window
- peak_pos_o  out  SAMPLE_CNT_DW  index of that sample
- C0_o, C1_o  out  C_DW  partial sums captured with the maximum
- state_o  out  2  debug: 0 WARMUP, 1 IDLE, 2 SEARCH, 3 HOLDOFF

## Operation
- Sample counter starts at 0 after reset and advances once per accepted sample (tvalid=1). It wraps modulo 2^SAMPLE_CNT_DW with no special handling.
- Moving average: delay line of WINDOW_LEN scores plus a running sum of width IN_DW+log2(WINDOW_LEN). The sum updates on every accepted sample in every state.
- Threshold = (sum >> log2(WINDOW_LEN)) << DETECTION_SHIFT, width IN_DW+DETECTION_SHIFT. It is computed from the sum *before* the current sample enters. Comparison is strict: score > threshold.
- WARMUP: no detection until WINDOW_LEN samples are accepted, then IDLE.
- IDLE: when score > threshold, enter SEARCH. The trigger sample is search sample 1 and seeds max value, position and C0/C1.
- SEARCH: for each accepted sample, replace max/position/C only if score > current max (strictly), so ties keep the earliest sample. After PEAK_WINDOW samples, pulse the output and enter HOLDOFF.
- HOLDOFF: count HOLDOFF_LEN accepted samples with no threshold evaluation, then IDLE.
- Inputs with tvalid=0 are ignored. All counters, state and delay line stall.
- Output registers hold the last report until the next report.

## Timing
- Reset: all outputs 0, state_o=0 (WARMUP), sum, delay line and counters cleared. Reset is asynchronous and takes effect at any time.
- Reset during SEARCH or HOLDOFF: the pending report is dropped, no pulse is issued, and warm-up restarts.
- Latency: m_axis_out_tvalid rises in the cycle after the clock edge that accepts the PEAK_WINDOW-th search sample. peak_* and C*_o update in that same cycle.
- state_o reflects the registered state, so transitions appear one cycle after the accepting edge.
- PEAK_WINDOW=1: report follows the trigger sample directly.
- HOLDOFF_LEN=0: go straight to IDLE after the report.

## Configuration
- PSS_PEAK_CFO_EN defined: C0_i/C1_i are captured with the running maximum and presented on C0_o/C1_o.
- Not defined: capture registers are not built, C0_o/C1_o are tied to 0, and C0_i/C1_i are unused. Ports exist in both builds.

## Test plan
Parameters: WINDOW_LEN=4, DETECTION_SHIFT=2, PEAK_WINDOW=4, HOLDOFF_LEN=8.
- Constant score 10 for 100 samples -> threshold 40, no m_axis_out_tvalid pulse; state_o=1 from sample 4 on.
- Score 1000 on samples 0–3, then 10 -> no report during WARMUP.
- Background 10, then idx20=100, idx21=200, idx22=150, idx23=10 -> one pulse the cycle after idx23 is accepted, peak_value_o=200, peak_pos_o=21. With PSS_PEAK_CFO_EN, C0_o/C1_o equal the idx21 inputs.
- Tie: idx21=idx22=200 -> peak_pos_o=21. The same scenario with tvalid gaps inserted gives an identical result.
- Holdoff: first peak as above, then 500 at idx25 (inside holdoff) -> ignored. 500 at idx40 -> second report with peak_pos_o=40.
- reset_i asserted at idx22 mid-SEARCH -> no pulse, all outputs 0, state_o=0. After release, the sample counter restarts at 0 and warm-up repeats.
